// File: rtl/dla_lane_skid_stage.sv
// -----------------------------------------------------------------------------
// dla_lane_skid_stage
// Elastic valid/ready register stage between the DLA multiplier array and the
// adder tree. Holds up to two beats (main + skid) so in_ready is a function of
// registered state only, and stores a pre-reduced lane sum with every beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   stall      global DLA stall, freezes all state and blocks transfers
//   flush      synchronous clear of both buffered beats
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (combinational from state + stall)
//   in_data    LANES lane products, WIDTH bits each
//   out_valid  output beat valid (combinational from state + stall)
//   out_ready  downstream accepts
//   out_data   registered lane products of the head beat
//   out_sum    registered full-precision sum of the head beat's lanes
//   occupancy  number of beats held (0..2)
// -----------------------------------------------------------------------------
module dla_lane_skid_stage #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned LANES  = 9,
   parameter bit          SIGNED = 1'b1,
   parameter int unsigned SUMW   = WIDTH + $clog2(LANES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data [LANES-1:0],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data [LANES-1:0],
   output logic [SUMW-1:0]  out_sum,
   output logic [1:0]       occupancy
);

   // Buffer fill state: main holds the head beat, skid the one behind it.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_alive;
   logic [WIDTH-1:0] r_main_data [LANES-1:0];
   logic [WIDTH-1:0] r_skid_data [LANES-1:0];
   logic [SUMW-1:0]  r_main_sum;
   logic [SUMW-1:0]  r_skid_sum;
   logic [SUMW-1:0]  w_in_sum;
   logic             w_main_valid;
   logic             w_skid_valid;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_main_ld_in;
   logic             w_main_ld_skid;
   logic             w_skid_ld;

   // Extend one lane to the sum width according to its signedness.
   function automatic logic [SUMW-1:0] lane_ext(input logic [WIDTH-1:0] v);
      if (SIGNED) begin
         return SUMW'($signed(v));
      end
      return SUMW'(v);
   endfunction

   // Lane reduction of the incoming beat; captured alongside the beat.
   always_comb begin
      w_in_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_in_sum = w_in_sum + lane_ext(in_data[i]);
      end
   end

   assign w_main_valid = (r_state != ST_EMPTY);
   assign w_skid_valid = (r_state == ST_FULL);

   // r_alive keeps in_ready low while reset is held and until the first edge.
   assign in_ready  = r_alive && !w_skid_valid && !stall;
   assign out_valid = w_main_valid && !stall;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
         r_alive <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_alive <= 1'b1;
      end
   end

   // Next-state and datapath load selects. Stall wins over flush.
   always_comb begin
      w_state_nxt    = r_state;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
      if (!stall) begin
         if (flush) begin
            w_state_nxt = ST_EMPTY;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_in_fire) begin
                     w_main_ld_in = 1'b1;
                     w_state_nxt  = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (w_in_fire && w_out_fire) begin
                     w_main_ld_in = 1'b1;
                  end else if (w_in_fire) begin
                     w_skid_ld   = 1'b1;
                     w_state_nxt = ST_FULL;
                  end else if (w_out_fire) begin
                     w_state_nxt = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  // in_ready is low here, so only the drain can happen.
                  if (w_out_fire) begin
                     w_main_ld_skid = 1'b1;
                     w_state_nxt    = ST_ONE;
                  end
               end
               default: begin
                  w_state_nxt = ST_EMPTY;
               end
            endcase
         end
      end
   end

   // Main and skid data/sum registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            r_main_data[i] <= '0;
            r_skid_data[i] <= '0;
         end
         r_main_sum <= '0;
         r_skid_sum <= '0;
      end else begin
         if (w_main_ld_in) begin
            r_main_data <= in_data;
            r_main_sum  <= w_in_sum;
         end else if (w_main_ld_skid) begin
            r_main_data <= r_skid_data;
            r_main_sum  <= r_skid_sum;
         end
         if (w_skid_ld) begin
            r_skid_data <= in_data;
            r_skid_sum  <= w_in_sum;
         end
      end
   end

   assign out_data  = r_main_data;
   assign out_sum   = r_main_sum;
   assign occupancy = 2'(w_main_valid) + 2'(w_skid_valid);

endmodule

// File: tb/tb_dla_lane_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_dla_lane_skid_stage
// Scoreboard bench: a queue-based FIFO reference (capacity 2) tracks accepted
// beats; a negedge monitor compares handshake, occupancy, head data and sums
// for a signed and an unsigned instance driven with identical stimulus.
// -----------------------------------------------------------------------------
module tb_dla_lane_skid_stage;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned LANES = 9;
   localparam int unsigned SUMW  = WIDTH + $clog2(LANES);

   typedef logic [WIDTH*LANES-1:0] beat_t;

   logic             clk;
   logic             rst;
   logic             stall;
   logic             flush;
   logic             in_valid;
   logic             out_ready;
   logic [WIDTH-1:0] in_data [LANES-1:0];
   logic             in_ready_s,  in_ready_u;
   logic             out_valid_s, out_valid_u;
   logic [WIDTH-1:0] out_data_s [LANES-1:0];
   logic [WIDTH-1:0] out_data_u [LANES-1:0];
   logic [SUMW-1:0]  out_sum_s, out_sum_u;
   logic [1:0]       occ_s, occ_u;

   int    n_checks = 0;
   int    n_errors = 0;
   beat_t exp_q[$];
   bit    m_alive = 1'b0;

   dla_lane_skid_stage #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_sum(out_sum_s), .occupancy(occ_s)
   );

   dla_lane_skid_stage #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
      .out_sum(out_sum_u), .occupancy(occ_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH*LANES-1:0] act,
                      input logic [WIDTH*LANES-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference lane sum from plain integer arithmetic.
   function automatic logic [SUMW-1:0] ref_sum(input beat_t b, input bit sgn);
      longint     acc;
      logic [WIDTH-1:0] v;
      acc = 0;
      for (int i = 0; i < LANES; i++) begin
         v = b[i*WIDTH +: WIDTH];
         if (sgn) acc += longint'($signed(v));
         else     acc += longint'(v);
      end
      return SUMW'(acc);
   endfunction

   function automatic beat_t pack_in();
      beat_t b;
      for (int i = 0; i < LANES; i++) b[i*WIDTH +: WIDTH] = in_data[i];
      return b;
   endfunction

   function automatic beat_t pack_s();
      beat_t b;
      for (int i = 0; i < LANES; i++) b[i*WIDTH +: WIDTH] = out_data_s[i];
      return b;
   endfunction

   function automatic beat_t pack_u();
      beat_t b;
      for (int i = 0; i < LANES; i++) b[i*WIDTH +: WIDTH] = out_data_u[i];
      return b;
   endfunction

   task automatic set_beat(input beat_t b);
      for (int i = 0; i < LANES; i++) in_data[i] = b[i*WIDTH +: WIDTH];
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor + reference model, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      bit    exp_rdy;
      bit    exp_ov;
      beat_t head;
      if (!rst) begin
         chk("rst_out_valid", out_valid_s, 0);
         chk("rst_in_ready",  in_ready_s,  0);
         chk("rst_occupancy", occ_s,       0);
         chk("rst_out_sum",   out_sum_s,   0);
         chk("rst_out_data",  pack_s(),    0);
         exp_q.delete();
         m_alive = 1'b0;
      end else begin
         exp_rdy = m_alive && (exp_q.size() < 2) && !stall;
         exp_ov  = (exp_q.size() > 0) && !stall;
         chk("in_ready",    in_ready_s,  exp_rdy);
         chk("out_valid",   out_valid_s, exp_ov);
         chk("occupancy",   occ_s,       exp_q.size());
         chk("u_out_valid", out_valid_u, exp_ov);
         chk("u_occupancy", occ_u,       exp_q.size());
         if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk("out_data",   pack_s(),  head);
            chk("out_sum",    out_sum_s, ref_sum(head, 1'b1));
            chk("u_out_data", pack_u(),  head);
            chk("u_out_sum",  out_sum_u, ref_sum(head, 1'b0));
         end
         // Advance the model for the coming edge.
         if (!stall) begin
            if (flush) begin
               exp_q.delete();
            end else begin
               if (exp_ov && out_ready) void'(exp_q.pop_front());
               if (exp_rdy && in_valid) exp_q.push_back(pack_in());
            end
         end
         m_alive = 1'b1;
      end
   end

   function automatic beat_t ramp_beat(input int k);
      beat_t b;
      for (int i = 0; i < LANES; i++) b[i*WIDTH +: WIDTH] = WIDTH'(i + 1 + k);
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 7))
            0:       b[i*WIDTH +: WIDTH] = 16'hFFFF;
            1:       b[i*WIDTH +: WIDTH] = 16'h8000;
            2:       b[i*WIDTH +: WIDTH] = 16'h7FFF;
            default: b[i*WIDTH +: WIDTH] = WIDTH'($urandom());
         endcase
      end
      return b;
   endfunction

   initial begin
      beat_t ones;
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      set_beat(ramp_beat(100));
      repeat (3) cyc();
      rst = 1'b1; in_valid = 1'b0;
      cyc();
      chk("ready_after_release", in_ready_s, 1);

      // Streaming at one beat per cycle.
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_beat(ramp_beat(k)); in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
      repeat (3) cyc();

      // All-ones lanes: signed -9 versus unsigned 9*65535.
      ones = '1;
      set_beat(ones); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ones_signed_sum",   out_sum_s, 20'hFFFF7);
      chk("ones_unsigned_sum", out_sum_u, 20'h8FFF7);
      cyc(); cyc();

      // Backpressure into the skid register, then drain.
      out_ready = 1'b0;
      set_beat(ramp_beat(10)); in_valid = 1'b1; cyc();
      set_beat(ramp_beat(20)); cyc();
      set_beat(ramp_beat(30)); repeat (2) cyc();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();

      // Stall while full.
      out_ready = 1'b0;
      set_beat(ramp_beat(40)); in_valid = 1'b1; cyc();
      set_beat(ramp_beat(50)); cyc();
      set_beat(ramp_beat(60)); stall = 1'b1; out_ready = 1'b1;
      repeat (5) cyc();
      stall = 1'b0; in_valid = 1'b0;
      repeat (3) cyc();

      // Flush while full with a beat on offer.
      out_ready = 1'b0;
      set_beat(ramp_beat(70)); in_valid = 1'b1; cyc();
      set_beat(ramp_beat(80)); cyc();
      set_beat(ramp_beat(90)); flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) cyc();

      // Flush held only during stall is ignored.
      set_beat(ramp_beat(5)); in_valid = 1'b1; out_ready = 1'b0; cyc();
      in_valid = 1'b0; stall = 1'b1; flush = 1'b1; cyc();
      stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) cyc();

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 9) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         set_beat(rand_beat());
         cyc();
      end
      stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();

      // Asynchronous reset between edges while one beat is held.
      out_ready = 1'b0;
      set_beat(ramp_beat(3)); in_valid = 1'b1; cyc();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid_s, 0);
      chk("async_rst_occupancy", occ_s,       0);
      chk("async_rst_out_sum",   out_sum_s,   0);
      repeat (2) cyc();
      rst = 1'b1;
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
